// File: rtl/y86_pkg.sv
// Shared Y86 encodings and default widths for the pipeline register slice.
package y86_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int ICODE_W_DEF = 4;
  localparam int REG_W_DEF   = 4;
  localparam int STAT_W_DEF  = 3;
  localparam int CNT_W_DEF   = 32;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline-register field: reset/bubble load a fixed NOP value, otherwise load or hold.
module pipe_field_reg #(
  parameter int             W          = 1,
  parameter logic [W-1:0]   BUBBLE_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         bubble,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST || bubble) begin
      q <= BUBBLE_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg_ctl.sv
// D->E pipeline register with stall/bubble control, valid tracking and sticky conflict flag.
// Optional stall/bubble performance counters are built when PERF_CNT_EN is defined.
module pipe_stage_reg_ctl
  import y86_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ICODE_W = ICODE_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int STAT_W  = STAT_W_DEF
`ifdef PERF_CNT_EN
  ,parameter int CNT_W  = CNT_W_DEF
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               E_stall,
  input  logic               E_bubble,
  input  logic [STAT_W-1:0]  D_status,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [ICODE_W-1:0] D_ifun,
  input  logic [REG_W-1:0]   D_rA,
  input  logic [REG_W-1:0]   D_rB,
  input  logic [DATA_W-1:0]  D_valC,
  input  logic [DATA_W-1:0]  D_valP,
  input  logic [DATA_W-1:0]  D_valA,
  input  logic [DATA_W-1:0]  D_valB,
  output logic [STAT_W-1:0]  e_status,
  output logic [ICODE_W-1:0] e_icode,
  output logic [ICODE_W-1:0] e_ifun,
  output logic [REG_W-1:0]   e_rA,
  output logic [REG_W-1:0]   e_rB,
  output logic [DATA_W-1:0]  e_valC,
  output logic [DATA_W-1:0]  e_valP,
  output logic [DATA_W-1:0]  e_valA,
  output logic [DATA_W-1:0]  e_valB,
  output logic               e_valid,
  output logic               ctl_err
`ifdef PERF_CNT_EN
  ,output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  // Bubble beats stall, so a field only loads when neither control is active.
  logic load;
  assign load = !E_stall && !E_bubble;

  pipe_field_reg #(.W(STAT_W), .BUBBLE_VAL(STAT_W'(SAOK))) u_status (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_status), .q(e_status)
  );
  pipe_field_reg #(.W(ICODE_W), .BUBBLE_VAL(ICODE_W'(INOP))) u_icode (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_icode), .q(e_icode)
  );
  pipe_field_reg #(.W(ICODE_W), .BUBBLE_VAL('0)) u_ifun (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_ifun), .q(e_ifun)
  );
  pipe_field_reg #(.W(REG_W), .BUBBLE_VAL(REG_W'(RNONE))) u_ra (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_rA), .q(e_rA)
  );
  pipe_field_reg #(.W(REG_W), .BUBBLE_VAL(REG_W'(RNONE))) u_rb (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_rB), .q(e_rB)
  );
  pipe_field_reg #(.W(DATA_W), .BUBBLE_VAL('0)) u_valc (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_valC), .q(e_valC)
  );
  pipe_field_reg #(.W(DATA_W), .BUBBLE_VAL('0)) u_valp (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_valP), .q(e_valP)
  );
  pipe_field_reg #(.W(DATA_W), .BUBBLE_VAL('0)) u_vala (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_valA), .q(e_valA)
  );
  pipe_field_reg #(.W(DATA_W), .BUBBLE_VAL('0)) u_valb (
    .CLK(CLK), .RST(RST), .bubble(E_bubble), .load(load), .d(D_valB), .q(e_valB)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      e_valid <= 1'b0;
      ctl_err <= 1'b0;
    end else begin
      if (E_bubble) begin
        e_valid <= 1'b0;
      end else if (!E_stall) begin
        e_valid <= 1'b1;
      end
      // Simultaneous stall and bubble means the control unit disagreed with itself.
      if (E_stall && E_bubble) begin
        ctl_err <= 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (E_stall && !E_bubble && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (E_bubble && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg_ctl.sv
// Randomised self-checking bench for pipe_stage_reg_ctl against a slot-level reference model.
module tb_pipe_stage_reg_ctl;

  localparam int VW     = 3 + 4 + 4 + 4 + 4 + 4 * 64;
  localparam int CNT_TB = 4;
  localparam int CMAX   = (1 << CNT_TB) - 1;
  localparam logic [VW-1:0] BUB = {3'd1, 4'd1, 4'd0, 4'hF, 4'hF, 256'd0};

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, E_stall, E_bubble;
  logic [2:0]  D_status, e_status;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, e_icode, e_ifun, e_rA, e_rB;
  logic [63:0] D_valC, D_valP, D_valA, D_valB, e_valC, e_valP, e_valA, e_valB;
  logic        e_valid, ctl_err;
`ifdef PERF_CNT_EN
  logic [CNT_TB-1:0] stall_cnt, bubble_cnt;
`endif

  pipe_stage_reg_ctl #(
    .DATA_W(64), .ICODE_W(4), .REG_W(4), .STAT_W(3)
`ifdef PERF_CNT_EN
    , .CNT_W(CNT_TB)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .E_stall(E_stall), .E_bubble(E_bubble),
    .D_status(D_status), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_valA(D_valA), .D_valB(D_valB),
    .e_status(e_status), .e_icode(e_icode), .e_ifun(e_ifun), .e_rA(e_rA), .e_rB(e_rB),
    .e_valC(e_valC), .e_valP(e_valP), .e_valA(e_valA), .e_valB(e_valB),
    .e_valid(e_valid), .ctl_err(ctl_err)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents of the execute slot and its side state.
  logic [VW-1:0] m_vec;
  logic          m_valid, m_err;
  int            m_scnt, m_bcnt;

  function automatic logic [VW-1:0] d_vec();
    return {D_status, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_valA, D_valB};
  endfunction

  function automatic logic [VW-1:0] e_vec();
    return {e_status, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valP, e_valA, e_valB};
  endfunction

  task automatic rand_d();
    D_status = 3'($urandom_range(0, 7));
    D_icode  = 4'($urandom_range(0, 15));
    D_ifun   = 4'($urandom_range(0, 15));
    D_rA     = 4'($urandom_range(0, 15));
    D_rB     = 4'($urandom_range(0, 15));
    D_valC   = {$urandom, $urandom};
    D_valP   = {$urandom, $urandom};
    D_valA   = {$urandom, $urandom};
    D_valB   = {$urandom, $urandom};
  endtask

  // Advance one clock: the model consumes the inputs present at the edge, outputs sampled #1 later.
  task automatic tick();
    logic [VW-1:0] dv;
    logic r, s, b;
    dv = d_vec();
    r = RST; s = E_stall; b = E_bubble;
    @(posedge CLK);
    if (r) begin
      m_vec = BUB; m_valid = 1'b0; m_err = 1'b0; m_scnt = 0; m_bcnt = 0;
    end else if (b) begin
      m_vec = BUB; m_valid = 1'b0;
      if (s) m_err = 1'b1;
      if (m_bcnt < CMAX) m_bcnt++;
    end else if (s) begin
      if (m_scnt < CMAX) m_scnt++;
    end else begin
      m_vec = dv; m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; E_stall = 1'b1; E_bubble = 1'b0; rand_d();
    tick();
    RST = 1'b0; E_stall = 1'b0;
    n_checks++;
    if (e_vec() !== BUB) begin
      n_fail++; $display("FAIL reset_fields got=%h exp=%h", e_vec(), BUB);
    end
    n_checks++;
    if (e_icode !== 4'd1 || e_status !== 3'd1 || e_rA !== 4'hF || e_rB !== 4'hF) begin
      n_fail++; $display("FAIL reset_named got icode=%0d status=%0d rA=%h rB=%h exp 1 1 F F",
                         e_icode, e_status, e_rA, e_rB);
    end
    n_checks++;
    if (e_valid !== 1'b0 || ctl_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got valid=%b err=%b exp 0 0", e_valid, ctl_err);
    end
  endtask

  task automatic test_load();
    rand_d(); D_icode = 4'd3; D_valC = 64'h1234;
    tick();
    n_checks++;
    if (e_icode !== 4'd3 || e_valC !== 64'h1234 || e_valid !== 1'b1) begin
      n_fail++; $display("FAIL load_basic got icode=%0d valC=%h valid=%b exp 3 1234 1",
                         e_icode, e_valC, e_valid);
    end
    n_checks++;
    if (e_vec() !== m_vec) begin
      n_fail++; $display("FAIL load_fields got=%h exp=%h", e_vec(), m_vec);
    end
  endtask

  task automatic test_stall();
    RST = 1'b1; tick(); RST = 1'b0;
    rand_d(); D_icode = 4'd6;
    tick();
    E_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d(); D_icode = 4'd7;
      tick();
      n_checks++;
      if (e_icode !== 4'd6 || e_valid !== 1'b1 || e_vec() !== m_vec) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got icode=%0d valid=%b exp 6 1", i, e_icode, e_valid);
      end
    end
    E_stall = 1'b0;
`ifdef PERF_CNT_EN
    n_checks++;
    if (stall_cnt !== 4'd3) begin
      n_fail++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt);
    end
`endif
  endtask

  task automatic test_bubble();
    int bc0;
    bc0 = m_bcnt;
    rand_d(); D_icode = 4'd5; E_bubble = 1'b1;
    tick();
    E_bubble = 1'b0;
    n_checks++;
    if (e_icode !== 4'd1 || e_valid !== 1'b0 || e_vec() !== BUB) begin
      n_fail++; $display("FAIL bubble_nop got icode=%0d valid=%b exp 1 0", e_icode, e_valid);
    end
`ifdef PERF_CNT_EN
    n_checks++;
    if (int'(bubble_cnt) !== bc0 + 1) begin
      n_fail++; $display("FAIL bubble_cnt got=%0d exp=%0d", bubble_cnt, bc0 + 1);
    end
`endif
    rand_d(); D_icode = 4'd2;
    tick();
    n_checks++;
    if (e_icode !== 4'd2 || e_valid !== 1'b1 || e_vec() !== m_vec) begin
      n_fail++; $display("FAIL bubble_next got icode=%0d valid=%b exp 2 1", e_icode, e_valid);
    end
  endtask

  task automatic test_conflict();
    rand_d(); E_stall = 1'b1; E_bubble = 1'b1;
    tick();
    E_stall = 1'b0; E_bubble = 1'b0;
    n_checks++;
    if (ctl_err !== 1'b1 || e_vec() !== BUB || e_valid !== 1'b0) begin
      n_fail++; $display("FAIL conflict_set got err=%b valid=%b exp 1 0", ctl_err, e_valid);
    end
    for (int i = 0; i < 5; i++) begin
      rand_d(); E_stall = (i == 2); E_bubble = (i == 3);
      tick();
    end
    E_stall = 1'b0; E_bubble = 1'b0;
    n_checks++;
    if (ctl_err !== 1'b1) begin
      n_fail++; $display("FAIL conflict_sticky got=%b exp=1", ctl_err);
    end
    RST = 1'b1; tick(); RST = 1'b0;
    n_checks++;
    if (ctl_err !== 1'b0) begin
      n_fail++; $display("FAIL conflict_clear got=%b exp=0", ctl_err);
    end
  endtask

  task automatic test_reset_mid();
    rand_d(); E_stall = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0; E_stall = 1'b0; E_bubble = 1'b0;
    rand_d();
    tick();
    n_checks++;
    if (e_vec() !== m_vec || e_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid got valid=%b vec=%h exp 1 %h", e_valid, e_vec(), m_vec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_d();
      RST      = ($urandom_range(0, 39) == 0);
      E_stall  = ($urandom_range(0, 3) == 0);
      E_bubble = ($urandom_range(0, 4) == 0);
      tick();
      n_checks++;
      if (e_vec() !== m_vec || e_valid !== m_valid || ctl_err !== m_err) begin
        n_fail++; $display("FAIL random cyc=%0d got valid=%b err=%b vec=%h exp %b %b %h",
                           i, e_valid, ctl_err, e_vec(), m_valid, m_err, m_vec);
      end
`ifdef PERF_CNT_EN
      n_checks++;
      if (int'(stall_cnt) !== m_scnt || int'(bubble_cnt) !== m_bcnt) begin
        n_fail++; $display("FAIL random_cnt cyc=%0d got s=%0d b=%0d exp %0d %0d",
                           i, stall_cnt, bubble_cnt, m_scnt, m_bcnt);
      end
`endif
    end
    RST = 1'b0; E_stall = 1'b0; E_bubble = 1'b0;
  endtask

`ifdef PERF_CNT_EN
  task automatic test_saturation();
    RST = 1'b1; tick(); RST = 1'b0;
    E_stall = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) tick();
    E_stall = 1'b0; E_bubble = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) tick();
    E_bubble = 1'b0;
    n_checks++;
    if (stall_cnt !== 4'hF || bubble_cnt !== 4'hF) begin
      n_fail++; $display("FAIL saturate got s=%0d b=%0d exp 15 15", stall_cnt, bubble_cnt);
    end
  endtask
`endif

  initial begin
    RST = 1'b0; E_stall = 1'b0; E_bubble = 1'b0; rand_d();
    m_vec = BUB; m_valid = 1'b0; m_err = 1'b0; m_scnt = 0; m_bcnt = 0;
    @(negedge CLK);
    test_reset();
    test_load();
    test_stall();
    test_bubble();
    test_conflict();
    test_reset_mid();
    test_random();
`ifdef PERF_CNT_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
